// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: funct codes,
// FSM and iteration-mode encodings, divide-by-zero quotient constant.
package muldiv_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam logic [63:0] DIV0_LO = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  typedef enum logic {
    M_MUL,
    M_DIV
  } mode_t;

  function automatic logic is_md_code(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                     F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage handshake between the pipeline and the HI/LO multiply/divide unit.
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             flush_i;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] rdata_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, funct_i, rs_i, rt_i, flush_i,
    input  busy_o, stall_o, done_o, rdata_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, funct_i, rs_i, rt_i, flush_i,
    output busy_o, stall_o, done_o, rdata_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide
// on unsigned magnitudes; {acc,op} is the working double-width register.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] op,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] op_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (op[0] ? {1'b0, m} : '0);
    sh      = {acc, op[WIDTH-1]};
    // Partial remainder stays below the divisor, so WIDTH+1 bits suffice and
    // the top bit of diff is a clean borrow flag.
    diff    = sh - {1'b0, m};
    acc_nxt = '0;
    op_nxt  = '0;
    if (mode == M_MUL) begin
      acc_nxt = sum[WIDTH:1];
      op_nxt  = {sum[0], op[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_nxt = diff[WIDTH-1:0];
      op_nxt  = {op[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = sh[WIDTH-1:0];
      op_nxt  = {op[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// MIPS MULT/MULTU/DIV/DIVU sequencer with the architectural HI/LO pair;
// magnitudes are iterated WIDTH cycles, signs applied in the FIX cycle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t             state;
  mode_t              mode;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, acc, op, m;
  logic [WIDTH-1:0]   acc_nxt, op_nxt;
  logic               neg_q, neg_r, div0, busy_r, done_r;

  logic               is_mul, is_div, sgn, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs, quo, rem;
  logic [2*WIDTH-1:0] prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode),
    .acc     (acc),
    .op      (op),
    .m       (m),
    .acc_nxt (acc_nxt),
    .op_nxt  (op_nxt)
  );

  always_comb begin
    is_mul = bus.funct_i inside {F_MULT, F_MULTU};
    is_div = bus.funct_i inside {F_DIV, F_DIVU};
    sgn    = ~bus.funct_i[0];
    rs_neg = sgn & bus.rs_i[WIDTH-1];
    rt_neg = sgn & bus.rt_i[WIDTH-1];
    rs_abs = rs_neg ? -bus.rs_i : bus.rs_i;
    rt_abs = rt_neg ? -bus.rt_i : bus.rt_i;
    prod   = neg_q ? -{acc, op} : {acc, op};
    // Zero divisor: acc ends up holding |rs|, so the remainder path rebuilds rs.
    quo    = div0 ? DIV0_LO[WIDTH-1:0] : (neg_q ? -op : op);
    rem    = neg_r ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mode   <= M_MUL;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      op     <= '0;
      m      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (bus.flush_i) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (is_mul || is_div) begin
              state  <= S_RUN;
              busy_r <= 1'b1;
              cnt    <= '0;
              acc    <= '0;
              mode   <= is_mul ? M_MUL : M_DIV;
              m      <= is_mul ? rs_abs : rt_abs;
              op     <= is_mul ? rt_abs : rs_abs;
              neg_q  <= rs_neg ^ rt_neg;
              neg_r  <= rs_neg;
              div0   <= is_div && (bus.rt_i == '0);
            end else if (bus.funct_i == F_MTHI) begin
              hi <= bus.rs_i;
            end else if (bus.funct_i == F_MTLO) begin
              lo <= bus.rs_i;
            end
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          op  <= op_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= S_FIX;
            done_r <= 1'b1;
          end
        end
        S_FIX: begin
          if (mode == M_MUL) begin
            {hi, lo} <= prod;
          end else begin
            hi <= rem;
            lo <= quo;
          end
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A flush in the FIX cycle suppresses the commit, so the pulse is masked too.
  assign bus.done_o  = done_r & ~bus.flush_i;
  assign bus.busy_o  = busy_r;
  assign bus.stall_o = busy_r & bus.start_i & is_md_code(bus.funct_i);
  assign bus.hi_o    = hi;
  assign bus.lo_o    = lo;
  assign bus.rdata_o = (bus.funct_i == F_MFHI) ? hi : lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table of mul/div results plus
// hand-written stall, flush, MTHI/MTLO, unknown-funct and reset sequences.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_BAD = 6'b011100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  muldiv_seq_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]   funct;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_cyc, output int done_cyc);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.funct_i = f;
    bus.rs_i    = a;
    bus.rt_i    = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.funct_i = 6'b000000;
    busy_cyc = 0;
    done_cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cyc++;
      if (bus.done_o) done_cyc = i;
      if (!bus.busy_o) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, dc, cyc;

    vecs[0]  = '{F_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{F_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
    vecs[4]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{F_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6]  = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[7]  = '{F_DIVU,  32'hFFFF_FFF9, 32'd2,        32'd1,         32'h7FFF_FFFC};
    vecs[8]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{F_MULTU, 32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780};
    vecs[10] = '{F_MULT,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
    vecs[11] = '{F_DIV,   32'd100,       32'd7,        32'd2,         32'd14};
    vecs[12] = '{F_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};

    bus.start_i = 1'b0;
    bus.funct_i = 6'b000000;
    bus.rs_i    = '0;
    bus.rt_i    = '0;
    bus.flush_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst hi", bus.hi_o, 0);
    chk("rst lo", bus.lo_o, 0);
    chk("rst busy", bus.busy_o, 0);
    chk("rst done", bus.done_o, 0);
    chk("rst stall", bus.stall_o, 0);
    rst_n = 1'b1;

    // MTHI / MTLO then immediate MFHI / MFLO
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct_i = F_MTHI; bus.rs_i = 32'h1234;
    @(posedge clk); #1;
    bus.funct_i = F_MFHI;
    @(negedge clk);
    chk("mthi rdata", bus.rdata_o, 32'h1234);
    chk("mfhi stall", bus.stall_o, 0);
    chk("mthi busy", bus.busy_o, 0);
    bus.funct_i = F_MTLO; bus.rs_i = 32'h5678;
    @(posedge clk); #1;
    bus.funct_i = F_MFLO;
    @(negedge clk);
    chk("mtlo rdata", bus.rdata_o, 32'h5678);
    chk("mtlo hi kept", bus.hi_o, 32'h1234);

    // Unknown funct has no effect
    bus.funct_i = F_BAD; bus.rs_i = 32'hFFFF; bus.rt_i = 32'h3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("bad busy", bus.busy_o, 0);
    chk("bad hi", bus.hi_o, 32'h1234);
    chk("bad lo", bus.lo_o, 32'h5678);

    // Flush in IDLE blocks MTHI and a multiply
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct_i = F_MTHI; bus.rs_i = 32'hDEAD;
    @(posedge clk); #1;
    bus.funct_i = F_MULT; bus.rt_i = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    chk("idle flush hi", bus.hi_o, 32'h1234);
    chk("idle flush busy", bus.busy_o, 0);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].funct, vecs[i].rs, vecs[i].rt, bc, dc);
      chk($sformatf("v%0d busy_cycles", i), bc, W + 1);
      chk($sformatf("v%0d done_cycle", i), dc, W + 1);
      chk($sformatf("v%0d hi", i), bus.hi_o, vecs[i].hi);
      chk($sformatf("v%0d lo", i), bus.lo_o, vecs[i].lo);
      bus.start_i = 1'b1; bus.funct_i = F_MFHI;
      #1;
      chk($sformatf("v%0d mfhi", i), bus.rdata_o, vecs[i].hi);
      bus.funct_i = F_MFLO;
      #1;
      chk($sformatf("v%0d mflo", i), bus.rdata_o, vecs[i].lo);
      bus.start_i = 1'b0;
    end

    // MULT followed by dependent MFLO held by stall; non-HI/LO op does not stall
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct_i = F_MULT; bus.rs_i = 32'd5; bus.rt_i = 32'd6;
    @(posedge clk); #1;
    bus.funct_i = F_ADD;
    @(negedge clk);
    chk("add busy", bus.busy_o, 1);
    chk("add nostall", bus.stall_o, 0);
    bus.funct_i = F_MFLO;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall_o) cyc++;
      else break;
    end
    chk("mflo stall_cycles", cyc, W);
    chk("mflo busy after", bus.busy_o, 0);
    chk("mflo rdata", bus.rdata_o, 32'd30);
    chk("mult hi", bus.hi_o, 0);
    bus.start_i = 1'b0;

    // Flush mid-DIV: no commit, no done pulse
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct_i = F_DIV; bus.rs_i = 32'd100; bus.rt_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    chk("flush pre busy", bus.busy_o, 1);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush busy", bus.busy_o, 0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done_o) dc++;
    end
    chk("flush done_count", dc, 0);
    chk("flush hi", bus.hi_o, 0);
    chk("flush lo", bus.lo_o, 32'd30);

    // Reset mid-RUN
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct_i = F_MULT; bus.rs_i = 32'hFFFF_FFFD; bus.rt_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst mid busy pre", bus.busy_o, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst mid hi", bus.hi_o, 0);
    chk("rst mid lo", bus.lo_o, 0);
    chk("rst mid busy", bus.busy_o, 0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) dc++;
    end
    chk("rst mid quiet", dc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
